// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, issues one read per instruction and presents the word to decode.
// Optional misaligned next-PC trap is enabled by defining IFU_MISALIGN_CHECK_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  output logic [31:0] fetch_cnt,
  output logic        fetch_err
);

`ifdef IFU_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2, ERR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;
`endif

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] cnt_r;
  logic        req_valid_r;
  logic        inst_valid_r;

`ifdef IFU_MISALIGN_CHECK_EN
  logic        err_r;
  logic        misaligned_s;

  assign misaligned_s = (next_pc[1:0] != 2'b00);
`endif

  // Fetch FSM; valids are registered alongside the state so outputs never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= REQ;
      pc_r         <= RESET_PC;
      inst_r       <= 32'h0000_0013;
      cnt_r        <= 32'd0;
      req_valid_r  <= 1'b1;
      inst_valid_r <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      err_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        REQ: begin
          if (req_ready) begin
            state_r     <= WAIT;
            req_valid_r <= 1'b0;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            inst_r       <= rsp_data;
            inst_valid_r <= 1'b1;
            state_r      <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            pc_r         <= next_pc;
            cnt_r        <= cnt_r + 32'd1;
            inst_valid_r <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            // The misaligned PC is committed so it can be inspected, but never fetched.
            if (misaligned_s) begin
              state_r <= ERR;
              err_r   <= 1'b1;
            end else begin
              state_r     <= REQ;
              req_valid_r <= 1'b1;
            end
`else
            state_r     <= REQ;
            req_valid_r <= 1'b1;
`endif
          end
        end
`ifdef IFU_MISALIGN_CHECK_EN
        ERR: begin
          state_r <= ERR;
        end
`endif
        default: begin
          state_r      <= REQ;
          req_valid_r  <= 1'b1;
          inst_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_valid  = req_valid_r;
  assign req_addr   = pc_r;
  assign inst_valid = inst_valid_r;
  assign inst       = inst_r;
  assign pc         = pc_r;
  assign fetch_cnt  = cnt_r;
`ifdef IFU_MISALIGN_CHECK_EN
  assign fetch_err  = err_r;
`else
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the single-cycle RV core, sitting directly upstream of the opcode control decoder. Holds the architectural PC, issues one 32-bit read per instruction over a valid/ready request channel, captures the response word and presents it with its PC to decode. Decode/execute returns the selected next PC (pc+4, pc+imm or ALU result) on the consume handshake, which starts the next fetch.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  out  1  instruction read request valid
- req_ready  in  1  memory accepts request
- req_addr  out  32  read address (= pc)
- rsp_valid  in  1  read data valid, one-cycle pulse
- rsp_data  in  32  instruction word
- inst_valid  out  1  instruction held for decode
- inst_ready  in  1  decode/execute consumes instruction this cycle
- inst  out  32  captured instruction; inst[6:0] drives decoder op
- pc  out  32  PC of inst
- next_pc  in  32  PC selected downstream, sampled on consume
- fetch_cnt  out  32  count of consumed instructions
- fetch_err  out  1  sticky misaligned-PC flag (see Configuration)

## Operation
- States: REQ, WAIT, HOLD, ERR (ERR only with macro). Moore outputs from registered state.
- REQ: req_valid=1, req_addr=pc. req_valid & req_ready -> WAIT.
- WAIT: req_valid=0. rsp_valid -> inst<=rsp_data, -> HOLD. rsp_valid outside WAIT ignored.
- HOLD: inst_valid=1; inst and pc stable. inst_valid & inst_ready -> pc<=next_pc, fetch_cnt<=fetch_cnt+1, -> REQ.
- ERR: all valids 0, fetch_err=1; exit only by reset.
- req_valid once asserted stays high with stable req_addr until accepted.
- fetch_cnt wraps 32'hFFFF_FFFF -> 0 silently.
- next_pc taken verbatim (no masking); width 32.

## Timing
- Reset (async assert, any state): state=REQ, pc=RESET_PC, inst=32'h0000_0013 (nop), fetch_cnt=0, fetch_err=0; hence req_valid=1, req_addr=RESET_PC, inst_valid=0 immediately during reset.
- Reset mid-fetch aborts the outstanding read; a late rsp_valid after deassert lands in REQ and is ignored.
- Minimum loop: request accepted cycle N, rsp_valid N+1, inst_valid N+2, consumed N+2, next req_valid N+3 (3 cycles/instruction).
- Request accept and response in same cycle not supported; response sampled only in WAIT.
- inst_ready while inst_valid=0 has no effect; next_pc ignored except on handshake.

## Configuration
- IFU_MISALIGN_CHECK_EN defined: on consume, if next_pc[1:0]!=0 then pc<=next_pc, fetch_cnt increments, state -> ERR, fetch_err=1 from next cycle; no request issued for that PC.
- Undefined: no check, ERR state absent, fetch_err tied 0; misaligned next_pc fetched as-is.

## Test plan
- Reset release, req_ready=1, rsp_data=32'h0010_0093 one cycle after accept -> req_addr=32'h8000_0000, inst_valid two cycles after accept, inst=32'h0010_0093, pc=32'h8000_0000.
- req_ready held 0 for 5 cycles -> req_valid stays 1, req_addr stable 32'h8000_0000, no state change; accept on cycle 6 -> WAIT.
- inst_ready=0 for 4 cycles in HOLD -> inst/pc stable, fetch_cnt=0; then inst_ready=1, next_pc=32'h8000_0010 -> next req_addr=32'h8000_0010, fetch_cnt=1.
- Sequence of jal-style redirects next_pc=32'h8000_0100, 32'h8000_0004 -> req_addr follows each, fetch_cnt=2.
- rst_n asserted while in WAIT, rsp_valid pulses after release with 32'hDEAD_BEEF -> pulse ignored, req_valid=1 at 32'h8000_0000, inst_valid=0.
- With IFU_MISALIGN_CHECK_EN: consume with next_pc=32'h8000_0002 -> fetch_err=1 next cycle, req_valid=0 permanently until reset; without macro -> req_addr=32'h8000_0002, fetch_err=0.
